// File: rtl/frequency_generator_pkg.sv
// Shared types and defaults for the programmable square-wave generator.
// Optional duty-cycle control is enabled with the DUTY_CTRL_EN macro.
package freq_gen_pkg;

  localparam int unsigned DEF_CLK_FS = 50_000_000;
  localparam int unsigned DEF_ACC_W  = 32;
  localparam int unsigned FREQ_W     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    PEND = 2'd2
  } fg_state_e;

endpackage

// File: rtl/frequency_generator_if.sv
// Frequency-request handshake: a transfer happens on a clk_fs edge where
// set_valid && set_ready; set_valid while set_ready=0 is ignored (no queueing).
interface frequency_generator_if;
  import freq_gen_pkg::*;

  logic [FREQ_W-1:0] fre_set;
  logic              set_valid;
  logic              set_ready;

  modport master (output fre_set, output set_valid, input set_ready);
  modport slave  (input fre_set, input set_valid, output set_ready);

endinterface

// File: rtl/frequency_generator_ftw_divider.sv
// Serial restoring divider: quotient = floor(dividend * 2^ACC_W / CLK_FS),
// one quotient bit per cycle for ACC_W cycles after start.
module ftw_divider
  import freq_gen_pkg::*;
#(
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned CLK_FS = DEF_CLK_FS
) (
  input  logic              clk_fs,
  input  logic              rst_n,
  input  logic              start,
  input  logic [FREQ_W-1:0] dividend,
  output logic              done,
  output logic [ACC_W-1:0]  quotient
);

  localparam int unsigned REM_W = FREQ_W + 1;
  localparam int unsigned CNT_W = $clog2(ACC_W + 1);
  localparam logic [REM_W-1:0] DIVISOR = REM_W'(CLK_FS);

  logic [FREQ_W-1:0] rem;
  logic [REM_W-1:0]  rem_sh;
  logic [REM_W-1:0]  rem_sub;
  logic [CNT_W-1:0]  cnt;
  logic              busy;
  logic              take;

  always_comb begin
    rem_sh  = {rem, 1'b0};
    take    = (rem_sh >= DIVISOR);
    rem_sub = rem_sh - DIVISOR;
  end

  // done marks the cycle computing the last bit; quotient is final after that edge.
  assign done = busy && (cnt == CNT_W'(ACC_W - 1));

  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      quotient <= '0;
    end else if (start) begin
      rem      <= dividend;
      cnt      <= '0;
      busy     <= 1'b1;
      quotient <= '0;
    end else if (busy) begin
      rem      <= take ? rem_sub[FREQ_W-1:0] : rem_sh[FREQ_W-1:0];
      quotient <= {quotient[ACC_W-2:0], take};
      cnt      <= cnt + CNT_W'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/frequency_generator.sv
// Programmable square-wave source: Hz request -> tuning word -> phase accumulator.
// Define DUTY_CTRL_EN to add the duty port (high time = duty/256).
module frequency_generator
  import freq_gen_pkg::*;
#(
  parameter int unsigned CLK_FS = DEF_CLK_FS,
  parameter int unsigned ACC_W  = DEF_ACC_W
) (
  input  logic                        clk_fs,
  input  logic                        rst_n,
  input  logic                        enable,
  frequency_generator_if.slave        set_if,
`ifdef DUTY_CTRL_EN
  input  logic [7:0]                  duty,
`endif
  output logic [ACC_W-1:0]            ftw,
  output logic                        wrap,
  output logic                        fx_out,
  output fg_state_e                   state
);

  localparam logic [FREQ_W-1:0] F_MAX = FREQ_W'(CLK_FS / 2);

  logic              set_ready_q;
  logic              xfer;
  logic [FREQ_W-1:0] f_clamped;
  logic              div_done;
  logic [ACC_W-1:0]  div_q;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W:0]    acc_sum;
  logic              fx_next;

  assign set_if.set_ready = set_ready_q;
  assign xfer      = set_if.set_valid && set_ready_q;
  assign f_clamped = (set_if.fre_set > F_MAX) ? F_MAX : set_if.fre_set;
  assign acc_sum   = {1'b0, acc} + {1'b0, ftw};

`ifdef DUTY_CTRL_EN
  assign fx_next = (acc[ACC_W-1 -: 8] < duty);
`else
  assign fx_next = acc[ACC_W-1];
`endif

  ftw_divider #(
    .ACC_W  (ACC_W),
    .CLK_FS (CLK_FS)
  ) u_div (
    .clk_fs   (clk_fs),
    .rst_n    (rst_n),
    .start    (xfer),
    .dividend (f_clamped),
    .done     (div_done),
    .quotient (div_q)
  );

  // New ftw lands only at a phase wrap (or when the output is idle) so the switch has no runt.
  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      set_ready_q <= 1'b1;
      ftw         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            state       <= CALC;
            set_ready_q <= 1'b0;
          end
        end
        CALC: begin
          if (div_done) state <= PEND;
        end
        PEND: begin
          if (wrap || !enable || (ftw == '0)) begin
            ftw         <= div_q;
            state       <= IDLE;
            set_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          set_ready_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_fs or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      wrap   <= 1'b0;
      fx_out <= 1'b0;
    end else if (!enable) begin
      acc    <= '0;
      wrap   <= 1'b0;
      fx_out <= 1'b0;
    end else if (ftw == '0) begin
      wrap   <= 1'b0;
      fx_out <= 1'b0;
    end else begin
      acc    <= acc_sum[ACC_W-1:0];
      wrap   <= acc_sum[ACC_W];
      fx_out <= fx_next;
    end
  end

endmodule

// File: tb/tb_frequency_generator.sv
// Directed bench for frequency_generator (CLK_FS=50 MHz, ACC_W=32).
// The duty scenario runs only when DUTY_CTRL_EN is defined.
module tb_frequency_generator;
  import freq_gen_pkg::*;

  localparam int unsigned ACC_W = 32;
  localparam logic [ACC_W-1:0] FTW_1M = 32'd85_899_345;
  localparam logic [ACC_W-1:0] FTW_2M = 32'd171_798_691;

  logic             clk_fs = 1'b0;
  logic             rst_n  = 1'b0;
  logic             enable = 1'b0;
  logic [ACC_W-1:0] ftw;
  logic             wrap;
  logic             fx_out;
  fg_state_e        state;
`ifdef DUTY_CTRL_EN
  logic [7:0]       duty = 8'd128;
`endif

  frequency_generator_if set_if ();

  logic [ACC_W-1:0] exp_q[$];
  logic [ACC_W-1:0] exp_ftw;
  int tests_run    = 0;
  int tests_failed = 0;

  frequency_generator #(.CLK_FS(50_000_000), .ACC_W(ACC_W)) dut (
    .clk_fs (clk_fs),
    .rst_n  (rst_n),
    .enable (enable),
    .set_if (set_if.slave),
`ifdef DUTY_CTRL_EN
    .duty   (duty),
`endif
    .ftw    (ftw),
    .wrap   (wrap),
    .fx_out (fx_out),
    .state  (state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk_fs = ~clk_fs;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, run=%0d failed=%0d", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic request(input logic [31:0] f);
    @(negedge clk_fs);
    set_if.fre_set   = f;
    set_if.set_valid = 1'b1;
    @(posedge clk_fs);
    #1 set_if.set_valid = 1'b0;
  endtask

  // Counts negedge samples with set_ready low, bounded.
  task automatic wait_ready(output int low);
    low = 0;
    @(negedge clk_fs);
    while (set_if.set_ready !== 1'b1 && low < 300) begin
      low++;
      @(negedge clk_fs);
    end
    tests_run++;
    if (set_if.set_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL ready_timeout: set_ready=%b after %0d cycles, need 1", set_if.set_ready, low);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk_fs);
    rst_n = 1'b0;
    @(negedge clk_fs);
    rst_n = 1'b1;
  endtask

  // Complete run lengths of fx_out (first, partial run discarded) plus wrap/high counts.
  task automatic measure(input int cycles, output int hmin, output int hmax,
                         output int lmin, output int lmax, output int wraps, output int highs);
    int run;
    logic prev;
    bit started;
    hmin = 1000; hmax = 0; lmin = 1000; lmax = 0; wraps = 0; highs = 0;
    @(negedge clk_fs);
    prev = fx_out; run = 1; started = 0;
    repeat (cycles) begin
      @(negedge clk_fs);
      if (wrap === 1'b1) wraps++;
      if (fx_out === 1'b1) highs++;
      if (fx_out === prev) run++;
      else begin
        if (started) begin
          if (prev === 1'b1) begin
            if (run < hmin) hmin = run;
            if (run > hmax) hmax = run;
          end else begin
            if (run < lmin) lmin = run;
            if (run > lmax) lmax = run;
          end
        end
        started = 1; prev = fx_out; run = 1;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_if.fre_set = '0; set_if.set_valid = 1'b0; enable = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk_fs);
    tests_run++;
    if (set_if.set_ready !== 1'b1 || ftw !== '0 || wrap !== 1'b0 || fx_out !== 1'b0 || state !== IDLE) begin
      tests_failed++;
      $display("FAIL reset_values: ready=%b ftw=%h wrap=%b fx=%b state=%0d, need 1/0/0/0/IDLE",
               set_if.set_ready, ftw, wrap, fx_out, state);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_1mhz();
    int low0, low1, hmin, hmax, lmin, lmax, wraps, highs;
    enable = 1'b1;
    request(32'd1_000_000);
    exp_q.push_back(FTW_1M);
    low0 = 0;
    // Requests presented while busy must be dropped.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_fs);
      if (set_if.set_ready === 1'b0) low0++;
      set_if.set_valid = (i < 2);
      set_if.fre_set   = 32'd7;
    end
    wait_ready(low1);
    exp_ftw = exp_q.pop_front();
    tests_run++;
    if (ftw !== exp_ftw) begin
      tests_failed++; $display("FAIL ftw_1mhz: got %0d, need %0d", ftw, exp_ftw);
    end
    // Transfer cycle aside: ACC_W CALC cycles plus one PEND cycle (ftw was 0).
    tests_run++;
    if (low0 + low1 != ACC_W + 1) begin
      tests_failed++; $display("FAIL ready_low_1mhz: got %0d, need %0d", low0 + low1, ACC_W + 1);
    end
    repeat (3) @(negedge clk_fs);
    tests_run++;
    if (state !== IDLE || set_if.set_ready !== 1'b1) begin
      tests_failed++; $display("FAIL no_queue: state=%0d ready=%b, need IDLE/1", state, set_if.set_ready);
    end
    measure(300, hmin, hmax, lmin, lmax, wraps, highs);
    tests_run++;
    if (hmin < 24 || hmax > 26 || lmin < 24 || lmax > 26) begin
      tests_failed++;
      $display("FAIL runs_1mhz: high %0d..%0d low %0d..%0d, need 24..26", hmin, hmax, lmin, lmax);
    end
  endtask

  task automatic test_clamp();
    int low, hmin, hmax, lmin, lmax, wraps, highs;
    request(32'd30_000_000);
    exp_q.push_back(32'h8000_0000);
    wait_ready(low);
    exp_ftw = exp_q.pop_front();
    tests_run++;
    if (ftw !== exp_ftw) begin
      tests_failed++; $display("FAIL ftw_clamp: got %h, need %h", ftw, exp_ftw);
    end
    measure(40, hmin, hmax, lmin, lmax, wraps, highs);
    tests_run++;
    if (hmin != 1 || hmax != 1 || lmin != 1 || lmax != 1) begin
      tests_failed++;
      $display("FAIL toggle_clamp: high %0d..%0d low %0d..%0d, need 1..1", hmin, hmax, lmin, lmax);
    end
    tests_run++;
    if (wraps != 20) begin
      tests_failed++; $display("FAIL wraps_clamp: got %0d, need 20", wraps);
    end
  endtask

  task automatic test_zero();
    int low, hmin, hmax, lmin, lmax, wraps, highs;
    pulse_reset();
    request(32'd0);
    exp_q.push_back('0);
    wait_ready(low);
    exp_ftw = exp_q.pop_front();
    tests_run++;
    if (ftw !== exp_ftw || low != ACC_W + 1) begin
      tests_failed++; $display("FAIL ftw_zero: ftw=%0d low=%0d, need %0d/%0d", ftw, low, exp_ftw, ACC_W + 1);
    end
    measure(100, hmin, hmax, lmin, lmax, wraps, highs);
    tests_run++;
    if (highs != 0 || wraps != 0) begin
      tests_failed++; $display("FAIL idle_zero: highs=%0d wraps=%0d, need 0/0", highs, wraps);
    end
  endtask

  task automatic test_phase_switch();
    int low, changes, bad, run, minrun;
    logic [ACC_W-1:0] prev_ftw;
    logic prev_wrap, prev_fx;
    bit started;
    request(32'd1_000_000);
    exp_q.push_back(FTW_1M);
    wait_ready(low);
    exp_ftw = exp_q.pop_front();
    tests_run++;
    if (ftw !== exp_ftw || low != ACC_W + 1) begin
      tests_failed++; $display("FAIL ftw_from_zero: ftw=%0d low=%0d, need %0d/%0d", ftw, low, exp_ftw, ACC_W + 1);
    end
    repeat (60) @(negedge clk_fs);
    exp_q.push_back(FTW_2M);
    changes = 0; bad = 0; run = 1; minrun = 1000; started = 0;
    prev_ftw = ftw; prev_wrap = wrap; prev_fx = fx_out;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_fs);
      if (ftw !== prev_ftw) begin
        changes++;
        if (prev_wrap !== 1'b1) bad++;
      end
      if (fx_out === prev_fx) run++;
      else begin
        if (started && run < minrun) minrun = run;
        started = 1; run = 1; prev_fx = fx_out;
      end
      prev_ftw = ftw; prev_wrap = wrap;
      set_if.set_valid = (i == 5);
      set_if.fre_set   = 32'd2_000_000;
    end
    exp_ftw = exp_q.pop_front();
    tests_run++;
    if (ftw !== exp_ftw) begin
      tests_failed++; $display("FAIL ftw_2mhz: got %0d, need %0d", ftw, exp_ftw);
    end
    tests_run++;
    if (changes != 1 || bad != 0) begin
      tests_failed++; $display("FAIL switch_at_wrap: changes=%0d off_wrap=%0d, need 1/0", changes, bad);
    end
    tests_run++;
    if (minrun < 12) begin
      tests_failed++; $display("FAIL no_runt: shortest run %0d, need >= 12", minrun);
    end
  endtask

  task automatic test_enable();
    int low, hmin, hmax, lmin, lmax, wraps, highs;
    @(negedge clk_fs);
    enable = 1'b0;
    @(negedge clk_fs);
    tests_run++;
    if (fx_out !== 1'b0 || wrap !== 1'b0) begin
      tests_failed++; $display("FAIL disable_clear: fx=%b wrap=%b, need 0/0", fx_out, wrap);
    end
    request(32'd1_000_000);
    exp_q.push_back(FTW_1M);
    wait_ready(low);
    exp_ftw = exp_q.pop_front();
    tests_run++;
    if (ftw !== exp_ftw || low != ACC_W + 1) begin
      tests_failed++; $display("FAIL ftw_disabled: ftw=%0d low=%0d, need %0d/%0d", ftw, low, exp_ftw, ACC_W + 1);
    end
    measure(60, hmin, hmax, lmin, lmax, wraps, highs);
    tests_run++;
    if (highs != 0 || wraps != 0) begin
      tests_failed++; $display("FAIL disabled_quiet: highs=%0d wraps=%0d, need 0/0", highs, wraps);
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid_calc();
    int low;
    request(32'd2_000_000);
    repeat (10) @(negedge clk_fs);
    tests_run++;
    if (state !== CALC) begin
      tests_failed++; $display("FAIL mid_calc_state: got %0d, need CALC", state);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (set_if.set_ready !== 1'b1 || ftw !== '0 || wrap !== 1'b0 || fx_out !== 1'b0 || state !== IDLE) begin
      tests_failed++;
      $display("FAIL async_reset: ready=%b ftw=%h wrap=%b fx=%b state=%0d, need 1/0/0/0/IDLE",
               set_if.set_ready, ftw, wrap, fx_out, state);
    end
    @(negedge clk_fs);
    rst_n = 1'b1;
    request(32'd1_000_000);
    exp_q.push_back(FTW_1M);
    wait_ready(low);
    exp_ftw = exp_q.pop_front();
    tests_run++;
    if (ftw !== exp_ftw || low != ACC_W + 1) begin
      tests_failed++; $display("FAIL after_reset: ftw=%0d low=%0d, need %0d/%0d", ftw, low, exp_ftw, ACC_W + 1);
    end
  endtask

`ifdef DUTY_CTRL_EN
  task automatic test_duty();
    int hmin, hmax, lmin, lmax, wraps, highs;
    @(negedge clk_fs);
    duty = 8'd64;
    measure(300, hmin, hmax, lmin, lmax, wraps, highs);
    tests_run++;
    if (hmin < 12 || hmax > 13) begin
      tests_failed++; $display("FAIL duty_64: high %0d..%0d, need 12..13", hmin, hmax);
    end
    duty = 8'd0;
    repeat (2) @(negedge clk_fs);
    measure(100, hmin, hmax, lmin, lmax, wraps, highs);
    tests_run++;
    if (highs != 0) begin
      tests_failed++; $display("FAIL duty_0: highs=%0d, need 0", highs);
    end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_1mhz();
    test_clamp();
    test_zero();
    test_phase_switch();
    test_enable();
    test_reset_mid_calc();
`ifdef DUTY_CTRL_EN
    test_duty();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
